// File: rtl/stoch_est_pkg.sv
// Shared types and width helpers for the stochastic matrix estimator.
// Honours STOCH_EST_BIPOLAR_EN (signed 2*count-WINDOW output, one extra bit).
package stoch_est_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int window(input int window_log2);
        return 1 << window_log2;
    endfunction

    function automatic int out_w(input int window_log2);
`ifdef STOCH_EST_BIPOLAR_EN
        return window_log2 + 2;
`else
        return window_log2 + 1;
`endif
    endfunction

endpackage

// File: rtl/stoch_est_cnt.sv
// Single-element ones counter with its count-to-estimate conversion.
// STOCH_EST_BIPOLAR_EN selects the signed bipolar estimate; default is the raw count.
module stoch_est_cnt
    import stoch_est_pkg::*;
#(
    parameter  int WINDOW_LOG2 = 8,
    localparam int CNT_W       = WINDOW_LOG2 + 1,
    localparam int OUT_W       = out_w(WINDOW_LOG2)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [OUT_W-1:0] o_est
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + CNT_W'(i_bit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Estimate includes the current bit so the final window sample is counted.
`ifdef STOCH_EST_BIPOLAR_EN
    localparam int WINDOW = window(WINDOW_LOG2);
    assign o_est = {w_cnt_nxt, 1'b0} - OUT_W'(WINDOW);
`else
    assign o_est = w_cnt_nxt;
`endif

endmodule

// File: rtl/stoch_mat_est.sv
// Matrix stochastic-to-binary estimator: counts ones per element over 2^WINDOW_LOG2 cycles.
// STOCH_EST_BIPOLAR_EN widens Y by one bit and reports signed 2*count-WINDOW.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | counting ones; Y loads on the last window cycle
// DONE  | one-cycle valid; start here chains the next window
module stoch_mat_est
    import stoch_est_pkg::*;
#(
    parameter  int NUM_ROWS    = 2,
    parameter  int NUM_COLS    = 2,
    parameter  int WINDOW_LOG2 = 8,
    localparam int OUT_W       = out_w(WINDOW_LOG2)
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      start,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]         A,
    output logic                                      busy,
    output logic                                      valid,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_W-1:0] Y
);

    state_t                                       r_state;
    state_t                                       w_state_nxt;
    logic [WINDOW_LOG2-1:0]                       r_cyc;
    logic                                         w_clr;
    logic                                         w_en;
    logic                                         w_load;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_W-1:0] w_est;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_W-1:0] r_y;

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACCUM;
                    w_clr       = 1'b1;
                end
            end
            ACCUM: begin
                w_en = 1'b1;
                if (r_cyc == '1) begin
                    w_load      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = ACCUM;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) begin
                r_cyc <= '0;
            end else if (w_en) begin
                r_cyc <= r_cyc + WINDOW_LOG2'(1);
            end
            if (w_load) begin
                r_y <= w_est;
            end
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            stoch_est_cnt #(
                .WINDOW_LOG2(WINDOW_LOG2)
            ) u_cnt (
                .i_clk(CLK),
                .i_rst(RST),
                .i_clr(w_clr),
                .i_en (w_en),
                .i_bit(A[r][c]),
                .o_est(w_est[r][c])
            );
        end
    end

    assign busy  = (r_state == ACCUM);
    assign valid = (r_state == DONE);
    assign Y     = r_y;

endmodule

// File: tb/tb_stoch_mat_est.sv
// Directed bench for stoch_mat_est with a 16-cycle window on a 2x2 matrix.
// Builds with or without STOCH_EST_BIPOLAR_EN; expected estimates follow the build.
module tb_stoch_mat_est;

    localparam int WL    = 4;
    localparam int WIN   = 16;
    localparam int OUT_W = stoch_est_pkg::out_w(WL);

    typedef logic [1:0][1:0]            a_t;
    typedef logic [1:0][1:0][OUT_W-1:0] y_t;

    logic CLK;
    logic RST;
    logic start;
    a_t   A;
    logic busy;
    logic valid;
    y_t   Y;

    int total = 0;
    int bad   = 0;

    stoch_mat_est #(
        .NUM_ROWS   (2),
        .NUM_COLS   (2),
        .WINDOW_LOG2(WL)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .start(start),
        .A    (A),
        .busy (busy),
        .valid(valid),
        .Y    (Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] est(input int cnt);
`ifdef STOCH_EST_BIPOLAR_EN
        return OUT_W'(2 * cnt - WIN);
`else
        return OUT_W'(cnt);
`endif
    endfunction

    function automatic y_t exp_y(input int c00, input int c01, input int c10, input int c11);
        y_t v;
        v[0][0] = est(c00);
        v[0][1] = est(c01);
        v[1][0] = est(c10);
        v[1][1] = est(c11);
        return v;
    endfunction

    // pat 0: zeros, 1: mixed rates, 2: ones, 3: all alternating (1 on odd samples)
    function automatic a_t a_pat(input int pat, input int k);
        a_t v;
        v = '0;
        case (pat)
            1: begin
                v[0][0] = 1'b1;
                v[0][1] = (k % 2 == 1);
                v[1][0] = (k % 4 == 0);
                v[1][1] = 1'b0;
            end
            2: v = '1;
            3: v = (k % 2 == 1) ? '1 : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Start at edge t, then watch edges t+1..t+20; optional start pulse at sample mid_k.
    task automatic run_win(input int pat, input int mid_k,
                           output int busy_n, output int valid_n, output int valid_at);
        start = 1'b1;
        tick();
        start    = 1'b0;
        busy_n   = busy ? 1 : 0;
        valid_n  = 0;
        valid_at = -1;
        for (int k = 1; k <= 20; k++) begin
            A     = (k <= WIN) ? a_pat(pat, k) : '0;
            start = (k == mid_k);
            tick();
            if (busy) busy_n++;
            if (valid) begin
                valid_n++;
                if (valid_at < 0) valid_at = k;
            end
        end
        start = 1'b0;
        A     = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; A = '0;
        tick(); tick();
        RST = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: busy=%b valid=%b want 0 0", busy, valid);
        end
        total++;
        if (Y !== '0) begin
            bad++; $display("FAIL reset_y: got %h want 0", Y);
        end
    endtask

    task automatic test_mixed();
        int bn, vn, va;
        run_win(1, 0, bn, vn, va);
        total++;
        if (va !== 16 || vn !== 1) begin
            bad++; $display("FAIL mixed_valid: at=%0d n=%0d want 16 1", va, vn);
        end
        total++;
        if (Y !== exp_y(16, 8, 4, 0)) begin
            bad++; $display("FAIL mixed_y: got %h want %h", Y, exp_y(16, 8, 4, 0));
        end
    endtask

    task automatic test_zero();
        int bn, vn, va;
        run_win(0, 0, bn, vn, va);
        total++;
        if (bn !== 16) begin
            bad++; $display("FAIL zero_busy: got %0d cycles want 16", bn);
        end
        total++;
        if (va !== 16 || vn !== 1) begin
            bad++; $display("FAIL zero_valid: at=%0d n=%0d want 16 1", va, vn);
        end
        total++;
        if (Y !== exp_y(0, 0, 0, 0)) begin
            bad++; $display("FAIL zero_y: got %h want %h", Y, exp_y(0, 0, 0, 0));
        end
    endtask

    task automatic test_mid_start();
        int bn, vn, va;
        run_win(2, 5, bn, vn, va);
        total++;
        if (va !== 16 || vn !== 1 || bn !== 16) begin
            bad++; $display("FAIL mid_start: at=%0d n=%0d busy=%0d want 16 1 16", va, vn, bn);
        end
        total++;
        if (Y !== exp_y(16, 16, 16, 16)) begin
            bad++; $display("FAIL ones_y: got %h want %h", Y, exp_y(16, 16, 16, 16));
        end
    endtask

    task automatic test_back_to_back();
        int v_first, v_second, vn;
        logic busy_after_done;
        y_t y_first;
        v_first = -1; v_second = -1; vn = 0; busy_after_done = 1'b0; y_first = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 16)                A = a_pat(2, k);
            else if (k >= 18 && k <= 33) A = a_pat(1, k - 17);
            else                        A = '0;
            start = (k == 17);
            tick();
            if (k == 17) busy_after_done = busy;
            if (valid) begin
                vn++;
                if (v_first < 0) begin
                    v_first = k;
                    y_first = Y;
                end else if (v_second < 0) begin
                    v_second = k;
                end
            end
        end
        start = 1'b0;
        total++;
        if (v_first !== 16 || v_second !== 33 || vn !== 2) begin
            bad++; $display("FAIL b2b_valid: first=%0d second=%0d n=%0d want 16 33 2", v_first, v_second, vn);
        end
        total++;
        if (busy_after_done !== 1'b1) begin
            bad++; $display("FAIL b2b_busy: got %b want 1", busy_after_done);
        end
        total++;
        if (y_first !== exp_y(16, 16, 16, 16)) begin
            bad++; $display("FAIL b2b_y1: got %h want %h", y_first, exp_y(16, 16, 16, 16));
        end
        total++;
        if (Y !== exp_y(16, 8, 4, 0)) begin
            bad++; $display("FAIL b2b_y2: got %h want %h", Y, exp_y(16, 8, 4, 0));
        end
    endtask

    task automatic test_reset_mid();
        int bn, vn, va, stray;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            A = a_pat(2, k);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        A   = '1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || Y !== '0) begin
            bad++; $display("FAIL rst_mid: busy=%b valid=%b y=%h want 0 0 0", busy, valid, Y);
        end
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid || busy) stray++;
        end
        A = '0;
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL rst_mid_idle: got %0d active cycles want 0", stray);
        end
        run_win(3, 0, bn, vn, va);
        total++;
        if (va !== 16 || vn !== 1) begin
            bad++; $display("FAIL rst_fresh_valid: at=%0d n=%0d want 16 1", va, vn);
        end
        total++;
        if (Y !== exp_y(8, 8, 8, 8)) begin
            bad++; $display("FAIL rst_fresh_y: got %h want %h", Y, exp_y(8, 8, 8, 8));
        end
    endtask

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        A     = '0;
        test_reset();
        test_mixed();
        test_zero();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
